// File: rtl/icache_param.sv
// Set-associative read-only instruction cache: round-robin replacement, line refill
// from backing memory over a beat stream, deferred flush during refill, hit/miss counters.
module icache_param #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned SET_ADDR_LEN  = 2,
    parameter int unsigned WAY_CNT       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_rd_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned TAG_LEN    = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int unsigned LINE_WORDS = 1 << LINE_ADDR_LEN;
    localparam int unsigned SETS       = 1 << SET_ADDR_LEN;
    localparam int unsigned WAY_W      = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam int unsigned IDX_LSB    = LINE_ADDR_LEN + 2;
    localparam int unsigned TAG_LSB    = IDX_LSB + SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, FILL, FILL_DONE} state_e;

    state_e                    state_q, state_d;
    logic [31-IDX_LSB:0]       fill_line_q, fill_line_d;
    logic [WAY_W-1:0]          victim_q, victim_d;
    logic [LINE_ADDR_LEN-1:0]  beat_q, beat_d;
    logic                      flush_pend_q, flush_pend_d;
    logic [31:0]               hit_cnt_q, miss_cnt_q;

    logic [WAY_CNT-1:0]        valid_q [SETS];
    logic [TAG_LEN-1:0]        tag_q   [SETS][WAY_CNT];
    logic [31:0]               data_q  [SETS][WAY_CNT][LINE_WORDS];
    logic [WAY_W-1:0]          ptr_q   [SETS];

    logic [LINE_ADDR_LEN-1:0]  req_off;
    logic [SET_ADDR_LEN-1:0]   req_set;
    logic [TAG_LEN-1:0]        req_tag;
    logic [SET_ADDR_LEN-1:0]   fill_set;
    logic [TAG_LEN-1:0]        fill_tag;
    logic                      way_hit, hit, flush_act, start_fill;
    logic                      addr_unused;

    assign req_off     = addr[IDX_LSB-1:2];
    assign req_set     = addr[TAG_LSB-1:IDX_LSB];
    assign req_tag     = addr[31:TAG_LSB];
    assign addr_unused = ^addr[1:0];
    assign fill_set    = fill_line_q[SET_ADDR_LEN-1:0];
    assign fill_tag    = fill_line_q[31-IDX_LSB:SET_ADDR_LEN];

    always_comb begin
        way_hit = 1'b0;
        rd_data = '0;
        for (int unsigned w = 0; w < WAY_CNT; w++) begin
            if (valid_q[req_set][WAY_W'(w)] && tag_q[req_set][WAY_W'(w)] == req_tag) begin
                way_hit = 1'b1;
                rd_data = data_q[req_set][WAY_W'(w)][req_off];
            end
        end
    end

    // A pending flush is served in the first IDLE cycle and takes priority over lookup.
    assign flush_act  = (state_q == IDLE) && (flush || flush_pend_q);
    assign hit        = (state_q == IDLE) && rd_req && !flush_act && way_hit;
    assign start_fill = (state_q == IDLE) && rd_req && !flush_act && !way_hit;
    assign miss       = (state_q != IDLE) || flush_act || (rd_req && !way_hit);
    assign mem_rd_req = (state_q == FILL);
    assign mem_addr   = {fill_line_q, {IDX_LSB{1'b0}}};
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        fill_line_d  = fill_line_q;
        victim_d     = victim_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            IDLE: begin
                if (flush_act) begin
                    flush_pend_d = 1'b0;
                end else if (start_fill) begin
                    state_d     = FILL;
                    fill_line_d = addr[31:IDX_LSB];
                    victim_d    = ptr_q[req_set];
                    beat_d      = '0;
                end
            end
            FILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_rd_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (&beat_q) state_d = FILL_DONE;
                end
            end
            FILL_DONE: begin
                if (flush) flush_pend_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_line_q  <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int unsigned s = 0; s < SETS; s++) valid_q[SET_ADDR_LEN'(s)] <= '0;
        end else begin
            state_q      <= state_d;
            fill_line_q  <= fill_line_d;
            victim_q     <= victim_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            if (hit && hit_cnt_q != '1)         hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (start_fill && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (flush_act) begin
                for (int unsigned s = 0; s < SETS; s++) valid_q[SET_ADDR_LEN'(s)] <= '0;
            end else if (state_q == FILL_DONE) begin
                valid_q[fill_set][victim_q] <= 1'b1;
            end
        end
    end

    // Line data and tags carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_rd_valid) data_q[fill_set][victim_q][beat_q] <= mem_rd_data;
        if (state_q == FILL_DONE)            tag_q[fill_set][victim_q]          <= fill_tag;
    end

    if (WAY_CNT > 1) begin : g_rr
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < SETS; s++) ptr_q[SET_ADDR_LEN'(s)] <= '0;
            end else if (flush_act) begin
                for (int unsigned s = 0; s < SETS; s++) ptr_q[SET_ADDR_LEN'(s)] <= '0;
            end else if (state_q == FILL_DONE) begin
                ptr_q[fill_set] <= ptr_q[fill_set] + 1'b1;
            end
        end
    end else begin : g_dm
        always_comb begin
            for (int unsigned s = 0; s < SETS; s++) ptr_q[SET_ADDR_LEN'(s)] = '0;
        end
    end
endmodule

// File: doc/icache_param.md
ICACHE_PARAM -- requirements
Module: icache_param

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter LINE_ADDR_LEN, default 3, SHALL give log2 of words per line.
REQ-003 Parameter SET_ADDR_LEN, default 2, SHALL give log2 of set count.
REQ-004 Parameter WAY_CNT, default 2, SHALL give ways per set (power of two, 1..8).
REQ-005 Derived TAG_LEN SHALL equal 30 - LINE_ADDR_LEN - SET_ADDR_LEN; LINE_WORDS = 2^LINE_ADDR_LEN.
REQ-006 Ports SHALL be:
 clk  in  1  rising-edge clock
 rst_n  in  1  async active-low reset
 rd_req  in  1  CPU fetch request
 addr  in  32  byte address; bits [1:0] ignored
 flush  in  1  invalidate-all request, one-cycle pulse
 rd_data  out  32  fetched word, valid when rd_req=1 and miss=0
 miss  out  1  stall to CPU
 mem_rd_req  out  1  line fill request to backing memory
 mem_addr  out  32  line base byte address, low LINE_ADDR_LEN+2 bits zero
 mem_rd_valid  in  1  one fill word delivered this cycle
 mem_rd_data  in  32  fill word, beats in ascending word order
 hit_cnt  out  32  hit counter
 miss_cnt  out  32  miss counter

Function
REQ-007 Address split SHALL be: word offset addr[LINE_ADDR_LEN+1:2], set index next SET_ADDR_LEN bits, tag remaining upper TAG_LEN bits.
REQ-008 Storage SHALL be per set per way: valid bit, TAG_LEN tag, LINE_WORDS x 32 data; one round-robin victim pointer (log2 WAY_CNT bits) per set.
REQ-009 FSM states SHALL be IDLE, FILL, FILL_DONE.
REQ-010 In IDLE, hit = rd_req and some way of the indexed set is valid with matching tag; rd_data SHALL be that way's word combinationally, miss=0.
REQ-011 In IDLE, rd_req without hit SHALL drive miss=1 combinationally and transition to FILL next edge, latching line base address and victim way = set's pointer.
REQ-012 miss SHALL be 1 in every FILL and FILL_DONE cycle; rd_data is don't-care while miss=1.
REQ-013 In FILL, mem_rd_req SHALL be held 1 and mem_addr stable; each cycle with mem_rd_valid=1 writes mem_rd_data to victim word at beat counter, counter increments.
REQ-014 mem_rd_valid may be 0 between beats (gaps unbounded); counter SHALL hold during gaps.
REQ-015 On the beat where counter = LINE_WORDS-1, FSM SHALL go to FILL_DONE; mem_rd_req SHALL be 0 from FILL_DONE onward.
REQ-016 FILL_DONE SHALL, for one cycle, write tag, set valid, advance set victim pointer modulo WAY_CNT, then return to IDLE, where the stalled request re-evaluates and hits.
REQ-017 CPU SHALL hold rd_req and addr stable while miss=1; addr changes during FILL are ignored.
REQ-018 flush in IDLE SHALL clear all valid bits and victim pointers at the edge; miss=1 in that cycle, no hit counted.
REQ-019 flush in FILL/FILL_DONE SHALL be latched pending; fill completes, then all valids clear in the first IDLE cycle (miss=1 that cycle), so the refetch misses again.
REQ-020 hit_cnt SHALL increment on each IDLE cycle with hit=1 and no flush action; miss_cnt on each IDLE->FILL transition; both saturate at 0xFFFFFFFF.
REQ-021 WAY_CNT=1 SHALL degenerate to direct-mapped with pointer logic removed.

Reset
REQ-022 rst_n=0 SHALL immediately force: state IDLE, mem_rd_req 0, mem_addr 0, beat counter 0, all valid bits 0, victim pointers 0, pending flush 0, hit_cnt 0, miss_cnt 0.
REQ-023 Data and tag arrays SHALL not be reset.
REQ-024 Reset during FILL SHALL abandon the fill; late mem_rd_valid beats after release in IDLE SHALL be ignored.

Verification (defaults: 8-word lines, 4 sets, 2 ways, set stride 0x80)
REQ-025 Cold read addr 0x10 -> miss=1, mem_addr=0x00, 8 beats 0xA0..0xA7, 2 cycles after last beat miss=0, rd_data=0xA4, miss_cnt=1.
REQ-026 Then read 0x1C -> miss=0 same cycle, rd_data=0xA7, hit_cnt=1.
REQ-027 Fill 0x000, 0x080, 0x100 (all set 0) -> third evicts 0x000; read 0x080 hits, read 0x000 misses, miss_cnt=4.
REQ-028 Fill with 3-cycle gaps between beats -> counter holds, line contents correct, mem_addr constant throughout.
REQ-029 flush pulse during beat 5 of a fill -> fill finishes, next IDLE cycle miss=1, valids cleared, same address then misses again.
REQ-030 rst_n low at beat 3 -> mem_rd_req=0 asynchronously, counters 0, next read of same line misses and refetches all 8 beats.
